seg_scan_ctrl: RTL
==================

Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for a multi-digit common-anode 7-segment display. It holds a shadow copy of NUM_DIGITS BCD digits and drives one shared bcd_to_7segment_decoder. It steps through the digits one at a time, asserting one active-low anode per digit, with an all-off guard interval between digits to prevent ghosting. It sits between the counter/ALU logic that produces the BCD values and the FPGA display pins.

Parameters:
NUM_DIGITS, 4, number of digits/anodes scanned; legal range 2..8.
REFRESH_DIV, 100000, clock cycles each digit is lit (SHOW phase); must be >= 2.
BLANK_CYCLES, 16, clock cycles all anodes are off before each digit (BLANK phase); must be >= 1.

Ports:
clk  in  1  system clock.
rst  in  1  asynchronous reset, active-high.
digits_in  in  4*NUM_DIGITS  BCD digits; digit k = bits [4k+3:4k]; digit 0 is least significant and rightmost.
dp_in  in  NUM_DIGITS  decimal-point request per digit, active-high.
load  in  1  one-cycle strobe that captures digits_in/dp_in into the shadow registers.
enable  in  1  scan enable; low blanks the display.
lz_suppress  in  1  high = blank leading zeros.
an  out  NUM_DIGITS  anode drive, active-low, at most one bit low at any time.
seg  out  7  segments {a,b,c,d,e,f,g}, active-low, a = MSB.
dp  out  1  decimal point, active-low.
frame_done  out  1  one-cycle pulse when the last digit's SHOW phase ends.

Behaviour:
- Reset (async, immediate): an = all 1s, seg = 7'b1111111, dp = 1, frame_done = 0, state = IDLE, digit index = 0, counter = 0. Each shadow digit = 4'hF (blank); shadow dp = 0.
- Shadow capture: on a clk edge with load=1, the shadow registers take digits_in/dp_in. This happens in any state. The shadow feeds the display only through cur_bcd/cur_dp.
- FSM states: IDLE, BLANK, SHOW.
  - IDLE: an all 1s, seg all 1s, dp 1. When enable=1, go to BLANK with index 0 and counter 0.
  - BLANK: an all 1s. Stay BLANK_CYCLES cycles. On the last cycle, latch cur_bcd/cur_dp from shadow[index], apply suppression, then go to SHOW.
  - SHOW: an[index] = 0 and all other anodes = 1; seg = decode(cur_bcd); dp = ~cur_dp. Stay REFRESH_DIV cycles. Then go to BLANK with index+1.
  - Index wrap: index NUM_DIGITS-1 wraps to 0. frame_done pulses on the same edge as the SHOW-to-BLANK transition for index NUM_DIGITS-1.
- Outputs are registered. New an/seg/dp values appear on the first cycle of a state. Full frame period = NUM_DIGITS*(BLANK_CYCLES+REFRESH_DIV) cycles.
- Leading-zero suppression, with lz_suppress=1: digit k is forced to 4'hF (blank) when shadow digit k and all higher digits are 0.
  - Digit 0 is never suppressed.
  - dp is still shown on a suppressed digit if its dp bit is set.
  - Evaluated at BLANK exit.
- Decoding: the shared decoder maps 0..9 to the standard active-low patterns. Non-BCD codes (A..F) give 7'b1111111, but the anode is still asserted.
- Load during SHOW: the currently lit digit is unchanged. New values take effect from the next BLANK exit.
- enable deasserted in BLANK or SHOW: on the next edge go to IDLE, outputs go all off, index = 0, and no frame_done pulse. Re-enable restarts with a BLANK phase at digit 0.
- load and enable falling on the same edge: the shadow still captures.
- Counter width = $clog2(max(REFRESH_DIV, BLANK_CYCLES)). The counter resets to 0 on every state change.

Decomposition:
- Shared package seg_pkg holds:
  - state enum (IDLE, BLANK, SHOW);
  - constant SEG_OFF = 7'b1111111;
  - constant BCD_BLANK = 4'hF.
- One sub-module: instantiate the existing bcd_to_7segment_decoder, driven by cur_bcd. Its output is registered into seg. The scan FSM, counter and suppression logic stay in seg_scan_ctrl.

Test Plan:
(All with NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=2.)
1. Async reset: assert rst mid-SHOW between edges -> immediately an=4'b1111, seg=7'b1111111, dp=1, frame_done=0. After release with enable=1, the first lit digit is digit 0.
2. Scan order: load 16'h1234, dp_in=4'b0000, enable=1.
   - Expect 2 cycles an=1111, then 4 cycles an=1110 with seg=7'b1001100 ("4").
   - Then 2 blank cycles, then an=1101 with seg=7'b0000110 ("3"), then "2" and "1".
   - frame_done pulses once per 24 cycles.
3. Leading zeros: load 16'h0070 with lz_suppress=1 -> digits 3 and 2 show 7'b1111111, digit 1 shows 7'b0001111, digit 0 shows 7'b0000001. With lz_suppress=0, digit 3 shows 7'b0000001.
4. Invalid code and dp: load 16'h00A5, dp_in=4'b0010, lz_suppress=0 -> digit 1 has an=1101, seg=7'b1111111, dp=0. Digit 0 shows 7'b0100100 with dp=1.
5. Load mid-SHOW: with digit 0 lit showing "4", pulse load with 16'h9999 -> seg stays 7'b1001100 until that SHOW ends. Digit 1 then shows 7'b0000100.
6. Enable drop: deassert enable during SHOW of digit 2 -> next cycle an=1111 and seg=7'b1111111, with no frame_done. Re-enable -> 2 blank cycles, then an=1110.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared types and constants for the 7-segment scan controller.
package seg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } scan_state_t;

  localparam logic [6:0] SEG_OFF   = 7'b1111111;
  localparam logic [3:0] BCD_BLANK = 4'hF;

  // Larger of two unsigned values, used to size the shared phase counter.
  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bcd_to_7segment_decoder.sv
// BCD to active-low 7-segment pattern {a,b,c,d,e,f,g}; non-BCD codes are dark.
module bcd_to_7segment_decoder
  import seg_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg_c
);

  // Pattern lookup.
  always_comb begin
    seg_c = SEG_OFF;
    case (bcd)
      4'd0:    seg_c = 7'b0000001;
      4'd1:    seg_c = 7'b1001111;
      4'd2:    seg_c = 7'b0010010;
      4'd3:    seg_c = 7'b0000110;
      4'd4:    seg_c = 7'b1001100;
      4'd5:    seg_c = 7'b0100100;
      4'd6:    seg_c = 7'b0100000;
      4'd7:    seg_c = 7'b0001111;
      4'd8:    seg_c = 7'b0000000;
      4'd9:    seg_c = 7'b0000100;
      default: seg_c = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode multi-digit 7-segment display.
// Each digit gets an all-off BLANK guard interval followed by a lit SHOW interval.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    enable,
  input  logic                    lz_suppress,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_done
);

  localparam int unsigned CNT_W = $clog2(max_u(REFRESH_DIV, BLANK_CYCLES));
  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  scan_state_t                state, state_nxt;
  logic [CNT_W-1:0]           cnt, cnt_nxt;
  logic [IDX_W-1:0]           idx, idx_nxt;
  logic [NUM_DIGITS-1:0][3:0] shadow_bcd;
  logic [NUM_DIGITS-1:0]      shadow_dp;
  logic [3:0]                 cur_bcd, cur_bcd_nxt;
  logic                       cur_dp, cur_dp_nxt;
  logic                       frame_done_nxt;
  logic [NUM_DIGITS-1:0]      an_nxt;
  logic [6:0]                 seg_nxt;
  logic                       dp_nxt;
  logic [NUM_DIGITS-1:0]      lz_zero;
  logic [6:0]                 dec_seg_c;

  // Shadow copy of the digits, captured on load regardless of scan state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_bcd <= {NUM_DIGITS{BCD_BLANK}};
      shadow_dp  <= '0;
    end else if (load) begin
      shadow_bcd <= digits_in;
      shadow_dp  <= dp_in;
    end
  end

  // lz_zero[k] is set when shadow digit k and every higher digit are zero.
  always_comb begin
    logic run;
    run     = 1'b1;
    lz_zero = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      run        = run && (shadow_bcd[k] == 4'h0);
      lz_zero[k] = run;
    end
  end

  // State, phase counter, digit index and the latched digit being displayed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      cur_bcd    <= BCD_BLANK;
      cur_dp     <= 1'b0;
      frame_done <= 1'b0;
      an         <= '1;
      seg        <= SEG_OFF;
      dp         <= 1'b1;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      idx        <= idx_nxt;
      cur_bcd    <= cur_bcd_nxt;
      cur_dp     <= cur_dp_nxt;
      frame_done <= frame_done_nxt;
      an         <= an_nxt;
      seg        <= seg_nxt;
      dp         <= dp_nxt;
    end
  end

  // Next-state logic; dropping enable overrides every phase transition.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt + CNT_W'(1);
    idx_nxt        = idx;
    cur_bcd_nxt    = cur_bcd;
    cur_dp_nxt     = cur_dp;
    frame_done_nxt = 1'b0;
    case (state)
      IDLE: begin
        idx_nxt = '0;
        if (enable) state_nxt = BLANK;
      end
      BLANK: begin
        if (!enable) begin
          state_nxt = IDLE;
          idx_nxt   = '0;
        end else if (cnt == BLANK_LAST) begin
          state_nxt   = SHOW;
          cur_bcd_nxt = (lz_suppress && (idx != '0) && lz_zero[idx]) ? BCD_BLANK
                                                                     : shadow_bcd[idx];
          cur_dp_nxt  = shadow_dp[idx];
        end
      end
      SHOW: begin
        if (!enable) begin
          state_nxt = IDLE;
          idx_nxt   = '0;
        end else if (cnt == SHOW_LAST) begin
          state_nxt      = BLANK;
          idx_nxt        = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
          frame_done_nxt = (idx == IDX_LAST);
        end
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = '0;
      end
    endcase
    if ((state_nxt != state) || (state_nxt == IDLE)) cnt_nxt = '0;
  end

  // Decoder sees the digit that will be latched, so seg is valid on the first SHOW cycle.
  bcd_to_7segment_decoder u_dec (
    .bcd   (cur_bcd_nxt),
    .seg_c (dec_seg_c)
  );

  // Display drive for the upcoming cycle; everything is dark outside SHOW.
  always_comb begin
    an_nxt  = '1;
    seg_nxt = SEG_OFF;
    dp_nxt  = 1'b1;
    if (state_nxt == SHOW) begin
      an_nxt  = ~(NUM_DIGITS'(1) << idx_nxt);
      seg_nxt = dec_seg_c;
      dp_nxt  = ~cur_dp_nxt;
    end
  end

endmodule
